// File: rtl/tvf_stream_engine_pkg.sv
// Shared definitions for the T/V/F stream engine: default geometry and the
// sequencer state encoding.
package tvf_stream_engine_pkg;

  localparam int unsigned SRAM_WORD_DEF = 64;
  localparam int unsigned VEF_BIT_DEF   = 16;
  localparam int unsigned DEPTH_DEF     = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_RECIRC = 2'd2,
    ST_DRAIN  = 2'd3
  } tvf_state_e;

endpackage

// File: rtl/tvf_fifo.sv
// Circular buffer holding returned {t,v,f} tuples between passes.
// Ports: clk/rst_n (async active-low); wr_en/wr_data push to the tail;
// rd_en pops the head, rd_data shows the head combinationally;
// full/empty/count report occupancy.
module tvf_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             rd_ok, wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = mem[rd_ptr];
  assign rd_ok   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign wr_ok   = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tvf_stream_engine.sv
// Streams a T sequence to PE 0, either unpacked from SRAM words (first pass)
// or replayed from the recirculation buffer, and collects the tuples coming
// back from the last PE into that buffer for the next pass.
// Ports: i_start/i_first/i_last/i_t_len configure a pass; o_sram_request,
// i_sram_valid, i_sram_data fetch packed T words; o_valid/i_pe_update_t with
// o_t/o_v/o_f/o_t_last form the element stream; i_ret_valid/i_t/i_v/i_f carry
// returned tuples; o_busy/o_done/o_overflow report pass status.
module tvf_stream_engine
  import tvf_stream_engine_pkg::*;
#(
  parameter int unsigned SRAM_WORD = SRAM_WORD_DEF,
  parameter int unsigned VEF_BIT   = VEF_BIT_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_first,
  input  logic                   i_last,
  input  logic [$clog2(DEPTH):0] i_t_len,
  output logic                   o_sram_request,
  input  logic                   i_sram_valid,
  input  logic [SRAM_WORD-1:0]   i_sram_data,
  output logic                   o_valid,
  input  logic                   i_pe_update_t,
  output logic [1:0]             o_t,
  output logic [VEF_BIT-1:0]     o_v,
  output logic [VEF_BIT-1:0]     o_f,
  output logic                   o_t_last,
  input  logic                   i_ret_valid,
  input  logic [1:0]             i_t,
  input  logic [VEF_BIT-1:0]     i_v,
  input  logic [VEF_BIT-1:0]     i_f,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow
);

  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned FCH_W    = CNT_W + 1;
  localparam int unsigned CHARS    = SRAM_WORD / 2;
  localparam int unsigned CHAR_LOG = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int unsigned ENT_W    = 2 + 2 * VEF_BIT;
  localparam logic [CHAR_LOG-1:0] LAST_CHAR  = CHAR_LOG'(CHARS - 1);
  localparam logic [FCH_W-1:0]    WORD_CHARS = FCH_W'(CHARS);

  tvf_state_e state, state_d;

  logic [CNT_W-1:0]     t_len_q, ld_cnt, recv_cnt;
  logic [FCH_W-1:0]     fch_cnt;
  logic                 last_q;
  logic [SRAM_WORD-1:0] word_q;
  logic                 word_vld;
  logic [CHAR_LOG-1:0]  char_idx;

  logic xfer, slot_free, more, start_ok, fetch_load, done_set, ovf_set;
  logic fifo_rd, fifo_wr, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0] buf_count_unused;

  tvf_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({i_t, i_v, i_f}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (buf_count_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // ld_cnt counts elements loaded into the output register; since that
  // register holds one element, the pass source is exhausted once
  // ld_cnt reaches t_len and the register has drained.
  always_comb begin
    state_d    = state;
    xfer       = o_valid && i_pe_update_t;
    slot_free  = !o_valid || xfer;
    more       = (ld_cnt < t_len_q);
    start_ok   = 1'b0;
    fetch_load = 1'b0;
    fifo_rd    = 1'b0;
    done_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_t_len == '0) begin
            done_set = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = i_first ? ST_FETCH : ST_RECIRC;
          end
        end
      end
      ST_FETCH: begin
        fetch_load = slot_free && more && word_vld;
        if (slot_free && !more) state_d = ST_DRAIN;
      end
      ST_RECIRC: begin
        fifo_rd = slot_free && more && !fifo_empty;
        if (slot_free && (!more || fifo_empty)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (recv_cnt == t_len_q) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    o_busy  = (state != ST_IDLE);
    fifo_wr = i_ret_valid && (state != ST_IDLE) && !last_q;
    ovf_set = fifo_wr && fifo_full && !fifo_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_len_q        <= '0;
      last_q         <= 1'b0;
      ld_cnt         <= '0;
      recv_cnt       <= '0;
      fch_cnt        <= '0;
      word_q         <= '0;
      word_vld       <= 1'b0;
      char_idx       <= '0;
      o_sram_request <= 1'b0;
      o_valid        <= 1'b0;
      o_t            <= '0;
      o_v            <= '0;
      o_f            <= '0;
      o_t_last       <= 1'b0;
      o_done         <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      o_done <= done_set;
      if (start_ok) begin
        t_len_q        <= i_t_len;
        last_q         <= i_last;
        ld_cnt         <= '0;
        recv_cnt       <= '0;
        fch_cnt        <= '0;
        word_vld       <= 1'b0;
        char_idx       <= '0;
        o_sram_request <= i_first;
        o_valid        <= 1'b0;
        o_t_last       <= 1'b0;
        o_overflow     <= 1'b0;
      end else begin
        if (i_ret_valid && o_busy) recv_cnt <= recv_cnt + 1'b1;
        if (ovf_set) o_overflow <= 1'b1;

        if (o_sram_request && i_sram_valid) begin
          word_q         <= i_sram_data;
          word_vld       <= 1'b1;
          char_idx       <= '0;
          fch_cnt        <= fch_cnt + WORD_CHARS;
          o_sram_request <= 1'b0;
        end

        if (fetch_load) begin
          o_t      <= word_q[{char_idx, 1'b0} +: 2];
          o_v      <= '0;
          o_f      <= '0;
          o_valid  <= 1'b1;
          o_t_last <= (ld_cnt == t_len_q - 1'b1);
          ld_cnt   <= ld_cnt + 1'b1;
          char_idx <= char_idx + 1'b1;
          // Word is spent either at its last character or at the pass end;
          // any remaining characters are dropped.
          if (char_idx == LAST_CHAR || ld_cnt + 1'b1 == t_len_q) begin
            word_vld <= 1'b0;
            if (fch_cnt < {1'b0, t_len_q}) o_sram_request <= 1'b1;
          end
        end else if (fifo_rd) begin
          {o_t, o_v, o_f} <= fifo_rd_data;
          o_valid  <= 1'b1;
          o_t_last <= (ld_cnt == t_len_q - 1'b1);
          ld_cnt   <= ld_cnt + 1'b1;
        end else if (xfer) begin
          o_valid  <= 1'b0;
          o_t_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tvf_stream_engine.sv
// Bench for tvf_stream_engine: a default-depth instance and a DEPTH=8
// instance share stimulus; `sel` chooses which one the model checks.
module tb_tvf_stream_engine;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] v;
    logic [15:0] f;
  } ent_s;

  typedef struct {
    int unsigned due;
    logic [1:0]  t;
    logic [15:0] v;
    logic [15:0] f;
  } pend_s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, first = 1'b0, last = 1'b0;
  logic [10:0] t_len = '0;
  logic        sram_valid = 1'b0;
  logic [63:0] sram_data = '0;
  logic        upd = 1'b0;
  logic        r_valid = 1'b0;
  logic [1:0]  r_t = '0;
  logic [15:0] r_v = '0, r_f = '0;
  logic        sel = 1'b0;

  logic        a_req, a_valid, a_last, a_busy, a_done, a_ovf;
  logic [1:0]  a_t;
  logic [15:0] a_v, a_f;
  logic        b_req, b_valid, b_last, b_busy, b_done, b_ovf;
  logic [1:0]  b_t;
  logic [15:0] b_v, b_f;

  logic        s_req, s_valid, s_last, s_busy, s_done, s_ovf;
  logic [1:0]  s_t;
  logic [15:0] s_v, s_f;
  logic [10:0] s_count;

  tvf_stream_engine dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_first(first), .i_last(last),
    .i_t_len(t_len), .o_sram_request(a_req), .i_sram_valid(sram_valid),
    .i_sram_data(sram_data), .o_valid(a_valid), .i_pe_update_t(upd),
    .o_t(a_t), .o_v(a_v), .o_f(a_f), .o_t_last(a_last),
    .i_ret_valid(r_valid), .i_t(r_t), .i_v(r_v), .i_f(r_f),
    .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf)
  );

  tvf_stream_engine #(.DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_first(first), .i_last(last),
    .i_t_len(t_len[3:0]), .o_sram_request(b_req), .i_sram_valid(sram_valid),
    .i_sram_data(sram_data), .o_valid(b_valid), .i_pe_update_t(upd),
    .o_t(b_t), .o_v(b_v), .o_f(b_f), .o_t_last(b_last),
    .i_ret_valid(r_valid), .i_t(r_t), .i_v(r_v), .i_f(r_f),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf)
  );

  assign s_req   = sel ? b_req   : a_req;
  assign s_valid = sel ? b_valid : a_valid;
  assign s_last  = sel ? b_last  : a_last;
  assign s_busy  = sel ? b_busy  : a_busy;
  assign s_done  = sel ? b_done  : a_done;
  assign s_ovf   = sel ? b_ovf   : a_ovf;
  assign s_t     = sel ? b_t     : a_t;
  assign s_v     = sel ? b_v     : a_v;
  assign s_f     = sel ? b_f     : a_f;
  assign s_count = sel ? 11'(dut_b.u_fifo.count) : dut_a.u_fifo.count;

  always #5 clk = ~clk;

  // Model state
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, n_req = 0, m_xfer = 0, m_tlen = 0, last_k = 0;
  bit          m_src = 1'b0, m_last = 1'b0, m_ovf = 1'b0, rnd_upd = 1'b0;
  bit          lat_wait = 1'b0, req_prev = 1'b0;
  logic [63:0] m_words [2];
  ent_s        m_buf [$];
  pend_s       ret_q [$];
  logic [1:0]  xt [64];
  logic [15:0] xv [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Input driver: PE returns, PE consume strobe, SRAM with one cycle of latency.
  initial begin
    pend_s r;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      r_valid = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        r_valid = 1'b1; r_t = r.t; r_v = r.v; r_f = r.f;
      end
      upd = rnd_upd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_req && !req_prev) n_req++;
      req_prev = s_req;
      if (sram_valid) begin
        sram_valid = 1'b0;
      end else if (s_req) begin
        if (lat_wait) begin
          sram_valid = 1'b1;
          sram_data  = m_words[(n_req >= 2) ? 1 : 0];
          lat_wait   = 1'b0;
        end else begin
          lat_wait = 1'b1;
        end
      end else begin
        lat_wait = 1'b0;
      end
    end
  end

  // Compare process: checks each transfer, stall hold and the overflow flag.
  initial begin
    bit          stall_p = 1'b0;
    logic [36:0] held = '0;
    logic [1:0]  et;
    logic [15:0] ev, ef;
    logic [63:0] w;
    ent_s        e;
    int unsigned k, depth;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_p = 1'b0;
        continue;
      end
      chk("o_overflow", s_ovf, m_ovf);
      if (stall_p) chk("stall_hold", {s_valid, s_t, s_v, s_f, s_last}, held);
      stall_p = s_valid && !upd;
      held    = {s_valid, s_t, s_v, s_f, s_last};
      if (s_valid && upd) begin
        k = m_xfer;
        et = '0; ev = '0; ef = '0;
        if (m_src) begin
          w  = m_words[(k / 32 >= 1) ? 1 : 0];
          et = 2'(w >> (2 * (k % 32)));
        end else if (m_buf.size() > 0) begin
          e = m_buf.pop_front();
          et = e.t; ev = e.v; ef = e.f;
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL buf_underrun: got transfer %0d expected none", k);
        end
        chk("o_t", s_t, et);
        chk("o_v", s_v, ev);
        chk("o_f", s_f, ef);
        chk("o_t_last", s_last, (k == m_tlen - 1));
        if (k < 64) begin
          xt[k] = s_t;
          xv[k] = s_v;
        end
        if (s_last) last_k = k;
        m_xfer++;
        ret_q.push_back('{due: cyc + 2, t: et, v: 16'(k), f: 16'(k + 100)});
      end
      depth = sel ? 8 : 1024;
      if (r_valid && !m_last) begin
        if (m_buf.size() < depth) m_buf.push_back('{t: r_t, v: r_v, f: r_f});
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (s_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, seen, 1'b1);
    @(posedge clk);
    #1;
    chk({name, "_done_pulse"}, s_done, 1'b0);
    chk({name, "_busy_after"}, s_busy, 1'b0);
  endtask

  task automatic launch(input bit f, input bit l, input int unsigned len, input bit rnd);
    m_src = f; m_last = l; m_tlen = len; m_xfer = 0; n_req = 0; rnd_upd = rnd;
    @(posedge clk);
    #1;
    first = f; last = l; t_len = 11'(len); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; first = 1'b0; last = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_clear();
    ret_q.delete();
    m_buf.delete();
    m_ovf = 1'b0;
    m_xfer = 0;
    rnd_upd = 1'b0;
  endtask

  initial begin
    m_words[0] = 64'hE4E4_E4E4_E4E4_E4E4;
    m_words[1] = 64'hFFFF_FFFF_FFFF_E4E4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {s_busy, s_done, s_ovf, s_req, s_valid, s_t, s_v, s_f, s_last}, '0);
    rst_n = 1'b1;

    // First pass from SRAM
    launch(1'b1, 1'b0, 40, 1'b0);
    wait_done("p1");
    chk("p1_xfers", m_xfer, 40);
    chk("p1_requests", n_req, 2);
    chk("p1_count", s_count, 40);
    chk("p1_last_idx", last_k, 39);
    chk("p1_t3", xt[3], 2'd3);
    chk("p1_t38", xt[38], 2'd2);

    // Recirculation pass with random consume stalls
    launch(1'b0, 1'b0, 40, 1'b1);
    wait_done("p2");
    chk("p2_xfers", m_xfer, 40);
    chk("p2_requests", n_req, 0);
    chk("p2_count", s_count, 40);
    chk("p2_v0", xv[0], 16'd0);
    chk("p2_v17", xv[17], 16'd17);
    chk("p2_v39", xv[39], 16'd39);

    // Zero-length pass
    rnd_upd = 1'b0; m_xfer = 0; n_req = 0;
    @(posedge clk);
    #1;
    first = 1'b1; t_len = '0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; first = 1'b0;
    chk("len0_done", s_done, 1'b1);
    chk("len0_busy", s_busy, 1'b0);
    @(posedge clk);
    #1;
    chk("len0_done_pulse", s_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_requests", n_req, 0);
    chk("len0_xfers", m_xfer, 0);

    // Reset in the middle of a FETCH pass
    launch(1'b1, 1'b0, 40, 1'b0);
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {s_busy, s_done, s_ovf, s_req, s_valid, s_t, s_v, s_f, s_last}, '0);
    chk("midreset_count", s_count, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(1'b1, 1'b0, 20, 1'b1);
    wait_done("p3");
    chk("p3_xfers", m_xfer, 20);
    chk("p3_requests", n_req, 1);
    chk("p3_count", s_count, 20);

    // Small buffer: overflow on the ninth return
    sel = 1'b1;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(1'b1, 1'b0, 9, 1'b0);
    wait_done("p4");
    chk("p4_overflow", s_ovf, 1'b1);
    chk("p4_count", s_count, 8);
    chk("p4_xfers", m_xfer, 9);
    launch(1'b0, 1'b1, 8, 1'b1);
    chk("p5_overflow_cleared", s_ovf, 1'b0);
    wait_done("p5");
    chk("p5_xfers", m_xfer, 8);
    chk("p5_v0", xv[0], 16'd0);
    chk("p5_v7", xv[7], 16'd7);
    chk("p5_count", s_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
